// File: rtl/multicycle_data_memory_if.sv
// Request/response bus between the CPU datapath and the multicycle data memory.
interface multicycle_data_memory_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] din;
   logic        resp_valid;
   logic [31:0] dout;
   logic        misaligned;

   modport master (
      output req_valid, mem_read, mem_write, addr, din,
      input  req_ready, resp_valid, dout, misaligned
   );

   modport slave (
      input  req_valid, mem_read, mem_write, addr, din,
      output req_ready, resp_valid, dout, misaligned
   );
endinterface

// File: rtl/multicycle_data_memory.sv
// Word-addressed data memory with a fixed multicycle access latency.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (suppresses misaligned accesses and flags them).
//
// state | meaning
// IDLE  | req_ready=1, waiting for a load/store request
// BUSY  | access in flight, latency down-counter running
// RESP  | one-cycle resp_valid pulse, result visible on dout
module multicycle_data_memory #(
   parameter int NUM_WORDS = 16384,
   parameter int LATENCY   = 4
) (
   input logic                   clk,
   input logic                   reset,
   multicycle_data_memory_if.slave bus
);
   localparam int AW = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    count, count_nxt;
   logic          accept, finish;
   logic [AW-1:0] idx_q;
   logic [31:0]   din_q;
   logic          wr_q;
   logic          mis_q;
   logic          mis_in;
   logic [31:0]   dout_q;
   logic [31:0]   mem [NUM_WORDS] = '{default: '0};
   logic          unused_addr;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign mis_in      = |bus.addr[1:0];
   assign unused_addr = ^bus.addr[31:AW+2];
`else
   assign mis_in      = 1'b0;
   assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
`endif

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid && (bus.mem_read || bus.mem_write)) begin
               accept    = 1'b1;
               count_nxt = 4'(LATENCY - 1);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (count == 4'd0) begin
               finish    = 1'b1;
               state_nxt = RESP;
            end else begin
               count_nxt = count - 4'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // A simultaneous load+store request is a store.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q <= bus.addr[AW+1:2];
         din_q <= bus.din;
         wr_q  <= bus.mem_write;
         mis_q <= mis_in;
      end
   end

   // The array itself is never reset; a reset on the completing edge cancels the store.
   always_ff @(posedge clk) begin
      if (!reset && finish && wr_q && !mis_q)
         mem[idx_q] <= din_q;
   end

   always_ff @(posedge clk) begin
      if (reset)
         dout_q <= 32'd0;
      else if (finish && !wr_q && !mis_q)
         dout_q <= mem[idx_q];
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.dout       = dout_q;
`ifdef DMEM_MISALIGN_CHECK_EN
   assign bus.misaligned = (state == RESP) && mis_q;
`else
   assign bus.misaligned = 1'b0;
`endif
endmodule
